// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive definitions.
//   rx_state_e        receiver FSM state encoding (2-bit)
//   DATA_BITS         payload bits per frame
//   FRAME_BITS        start + data + stop bits
//   DEF_CLKS_PER_BIT  default bit period in clock cycles
//   majority3()       2-of-3 vote used by the optional line filter
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned FRAME_BITS       = 10;
  localparam int unsigned DEF_CLKS_PER_BIT = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous UART line into the clk domain.
//   clk_i     system clock
//   rst_i     synchronous active-high reset (flops preset to line-idle 1)
//   rx_i      raw asynchronous serial input
//   rx_s_o    2-flop synchronised line, used for start-edge detection
//   sample_o  value the FSM uses on a sample tick
// Build option UART_RX_MAJORITY_EN: sample_o is the majority of rx_s over
// the current and two previous cycles; otherwise sample_o is rx_s itself.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic sample_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] = rx_s one cycle ago, hist_q[1] = two cycles ago.
  logic [1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '1;
    end else begin
      hist_q <= {hist_q[0], sync_q};
    end
  end

  assign sample_o = majority3(sync_q, hist_q[0], hist_q[1]);
`else
  assign sample_o = sync_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, CLKS_PER_BIT cycles per bit.
//   clk        system clock
//   rst        synchronous active-high reset; aborts any frame silently
//   rx         asynchronous serial input, idles high
//   rx_data    last correctly framed byte, held until the next good frame
//   rx_valid   one-cycle pulse: rx_data was just updated
//   frame_err  one-cycle pulse: stop bit sampled low
//   rx_busy    high whenever the FSM is not idle
// Build option UART_RX_MAJORITY_EN enables 3-sample majority filtering in
// uart_rx_sync; sample-tick timing is the same either way.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;
  logic sample;

  uart_rx_sync u_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_i     (rx),
    .rx_s_o   (rx_s),
    .sample_o (sample)
  );

  rx_state_e            state_q,     state_d;
  logic [CNT_W-1:0]     clk_count_q, clk_count_d;
  logic [2:0]           bit_count_q, bit_count_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 armed_q,     armed_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      armed_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      armed_q     <= armed_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q + 1'b1;
    bit_count_d = bit_count_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    armed_d     = armed_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        clk_count_d = '0;
        // armed must see the line high first, so a held break or the tail
        // of a bad frame cannot start a new frame.
        if (rx_s) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (clk_count_q == HALF_LAST) begin
          clk_count_d = '0;
          if (!sample) begin
            state_d     = RX_DATA;
            bit_count_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          shreg_d     = {sample, shreg_q[DATA_BITS-1:1]};
          bit_count_d = bit_count_q + 3'd1;
          if (bit_count_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          state_d     = RX_IDLE;
          if (sample) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
    rx_busy   = (state_q != RX_IDLE);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at 8 clocks per bit.
// The stimulus process pushes each expected rx_valid / frame_err event into
// a queue; the monitor pops one per observed pulse and compares.
module tb_uart_receiver;

  localparam int unsigned CPB = 8;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  exp_t       exp_q[$];
  int         n_tests;
  int         n_fail;
  logic [7:0] last_good;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Entered at a negedge: drive v and keep it for n rising edges.
  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // glitch inverts one cycle per data bit, timed so the synchronised line
  // is wrong exactly on the receiver's sample tick.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic glitch);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (glitch) begin
        hold(b[i], 4);
        hold(~b[i], 1);
        hold(b[i], CPB - 5);
      end else begin
        hold(b[i], CPB);
      end
    end
    hold(stop_v, CPB);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{is_err: 1'b0, data: b});
    last_good = b;
  endtask

  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h, expected no pulse (t=%0t)",
                 rx_valid, frame_err, rx_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("busy_after_frame", {31'd0, rx_busy}, 32'd0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    last_good = 8'h00;
    rst       = 1'b1;
    rx        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // Single byte.
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);

    // Back-to-back frames with no idle gap, as a transmitter produces them.
    expect_byte(8'h3C);
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);

    // Two-cycle low glitch: START entered, then aborted at the half-bit sample.
    hold(1'b0, 2);
    hold(1'b1, 1);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    hold(1'b1, 2 * CPB);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);

    // Bad stop bit, then a long break, then a good frame.
    exp_q.push_back('{is_err: 1'b1, data: last_good});
    send_frame(8'h55, 1'b0, 1'b0);
    hold(1'b0, 200);
    check("break_no_restart", {31'd0, rx_busy}, 32'd0);
    hold(1'b1, 2 * CPB);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);

    // Reset partway through bit 3 of 8'hC3 (bit 3 is 0).
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, 4);
    rst = 1'b1;
    hold(1'b0, 1);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    hold(1'b1, 3 * CPB);
    expect_byte(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);

    // Sample-tick glitches on every data bit of 8'h96: filtered build
    // recovers it, unfiltered build samples every data bit inverted.
`ifdef UART_RX_MAJORITY_EN
    expect_byte(8'h96);
`else
    expect_byte(8'h69);
`endif
    send_frame(8'h96, 1'b1, 1'b1);
    hold(1'b1, 3 * CPB);

    check("pending_events", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
